// File: rtl/lock_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
// Shared definitions for the lock datapath: the display packet type, special
// BCD display codes, keypad codes, the PIN entry state enum and small
// elaboration-time helpers.
// -----------------------------------------------------------------------------
package lock_pkg;

    // Display packet: six 4-bit BCD positions, index 0 (BCD0) is the newest
    // digit and sits in bits [3:0].
    typedef logic [5:0][3:0] bcdPac_t;

    localparam int PIN_MAX_LEN = 6;

    // Non-numeric display codes understood by the 7-segment stage.
    localparam logic [3:0] BCD_DASH  = 4'hA;
    localparam logic [3:0] BCD_BLANK = 4'hB;

    // Keypad edit codes; 0-9 are digits, anything else is ignored.
    localparam logic [3:0] KEY_SUBMIT = 4'hC;
    localparam logic [3:0] KEY_BKSP   = 4'hD;
    localparam logic [3:0] KEY_CLEAR  = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_HOLD  = 2'd2
    } pin_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pin_entry_buffer_if.sv
// -----------------------------------------------------------------------------
// pin_entry_buffer_if
// Bundles the keypad handshake, the display drive and the lock-control PIN
// outputs of pin_entry_buffer.
//   key_valid / key_code / key_ready : keypad event handshake
//   bcd_packet / enable_o            : 7-segment display stage drive
//   pin_valid / pin_error / pin_timeout : one-cycle event pulses
//   pin_digits / pin_len             : raw PIN contents and digit count
// Modports: master = keypad/consumer side, slave = pin_entry_buffer.
// -----------------------------------------------------------------------------
interface pin_entry_buffer_if;
    import lock_pkg::*;

    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    bcdPac_t     bcd_packet;
    logic        enable_o;
    logic        pin_valid;
    logic        pin_error;
    logic        pin_timeout;
    logic [23:0] pin_digits;
    logic [2:0]  pin_len;

    modport master (
        output key_valid, key_code,
        input  key_ready, bcd_packet, enable_o,
        input  pin_valid, pin_error, pin_timeout, pin_digits, pin_len
    );

    modport slave (
        input  key_valid, key_code,
        output key_ready, bcd_packet, enable_o,
        output pin_valid, pin_error, pin_timeout, pin_digits, pin_len
    );

endinterface

// File: rtl/pin_entry_buffer_down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
// Loadable down-counter that decrements every clock and saturates at zero.
//   clk, rst     : clock, asynchronous active-high reset (count -> 0)
//   i_load       : load i_load_val this cycle (has priority over decrement)
//   i_load_val   : value to load
//   o_expired    : count is zero
// -----------------------------------------------------------------------------
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/pin_entry_buffer.sv
// -----------------------------------------------------------------------------
// pin_entry_buffer
// Operational-mode keypad entry stage. Accumulates a PIN of up to six digits,
// drives the BCD packet and enable of the downstream 7-segment stage, reports
// the finished PIN to lock control on submit and clears itself when idle too
// long in ENTRY.
//   clk     : clock
//   rst     : asynchronous reset, active-high
//   io_pin  : pin_entry_buffer_if.slave (keypad handshake, display, PIN out)
// Parameters: MIN_LEN, TIMEOUT_CYCLES, HOLD_CYCLES, REVEAL_CYCLES.
// Optional feature macro: PIN_MASK_EN -- masks held digits with BCD_DASH and
// shows the newest digit raw only for REVEAL_CYCLES after it is entered.
// -----------------------------------------------------------------------------
module pin_entry_buffer
    import lock_pkg::*;
#(
    parameter int MIN_LEN        = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int HOLD_CYCLES    = 25_000_000,
    parameter int REVEAL_CYCLES  = 12_500_000
) (
    input  logic               clk,
    input  logic               rst,
    pin_entry_buffer_if.slave  io_pin
);

    localparam int TW = $clog2(max_int(TIMEOUT_CYCLES, HOLD_CYCLES) + 1);

    // The timer flags expiry once it has counted down to zero, which happens
    // N-1 edges after loading N-1; the state change then lands exactly N edges
    // after the load.
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LOAD    = TW'(HOLD_CYCLES - 1);

    pin_state_t r_state,  w_state_nxt;
    bcdPac_t    r_digits, w_digits_nxt;
    logic [2:0] r_len,    w_len_nxt;
    logic       r_pin_valid,   w_pin_valid_nxt;
    logic       r_pin_error,   w_pin_error_nxt;
    logic       r_pin_timeout, w_pin_timeout_nxt;

    logic          w_take;
    logic          w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic          w_tmr_expired;

    assign io_pin.key_ready = (r_state != ST_HOLD);
    assign w_take           = io_pin.key_valid && io_pin.key_ready;

    // Inactivity / hold timer, shared because ENTRY and HOLD never overlap.
    down_timer #(.WIDTH(TW)) u_idle_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expired  (w_tmr_expired)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt       = r_state;
        w_digits_nxt      = r_digits;
        w_len_nxt         = r_len;
        w_pin_valid_nxt   = 1'b0;
        w_pin_error_nxt   = 1'b0;
        w_pin_timeout_nxt = 1'b0;
        w_tmr_load        = 1'b0;
        w_tmr_val         = TIMEOUT_LOAD;

        unique case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_tmr_load   = 1'b1;
                    // Any accepted key retires the previously submitted PIN.
                    w_digits_nxt = '0;
                    if (is_digit(io_pin.key_code)) begin
                        w_digits_nxt[0] = io_pin.key_code;
                        w_len_nxt       = 3'd1;
                        w_state_nxt     = ST_ENTRY;
                    end
                end
            end

            ST_ENTRY: begin
                if (w_take) begin
                    // A key in the expiry cycle wins over the timeout.
                    w_tmr_load = 1'b1;
                    if (is_digit(io_pin.key_code)) begin
                        if (int'(r_len) < PIN_MAX_LEN) begin
                            w_digits_nxt = {r_digits[4:0], io_pin.key_code};
                            w_len_nxt    = r_len + 3'd1;
                        end
                    end else begin
                        case (io_pin.key_code)
                            KEY_BKSP: begin
                                w_digits_nxt = {4'h0, r_digits[5:1]};
                                w_len_nxt    = r_len - 3'd1;
                                if (r_len == 3'd1) begin
                                    w_state_nxt = ST_IDLE;
                                end
                            end
                            KEY_CLEAR: begin
                                w_digits_nxt = '0;
                                w_len_nxt    = 3'd0;
                                w_state_nxt  = ST_IDLE;
                            end
                            KEY_SUBMIT: begin
                                if (int'(r_len) >= MIN_LEN) begin
                                    w_pin_valid_nxt = 1'b1;
                                    w_tmr_val       = HOLD_LOAD;
                                    w_state_nxt     = ST_HOLD;
                                end else begin
                                    w_pin_error_nxt = 1'b1;
                                    w_digits_nxt    = '0;
                                    w_len_nxt       = 3'd0;
                                    w_state_nxt     = ST_IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end else if (w_tmr_expired) begin
                    w_pin_timeout_nxt = 1'b1;
                    w_digits_nxt      = '0;
                    w_len_nxt         = 3'd0;
                    w_state_nxt       = ST_IDLE;
                end
            end

            ST_HOLD: begin
                // Digits are kept so pin_digits stays valid for lock control
                // until the next accepted key; len=0 blanks the display.
                if (w_tmr_expired) begin
                    w_len_nxt   = 3'd0;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_digits_nxt = '0;
                w_len_nxt    = 3'd0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    // NOTE: the six-entry digit store is reset along with the control state
    // because pin_digits is an observable output with a defined reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_digits      <= '0;
            r_len         <= 3'd0;
            r_pin_valid   <= 1'b0;
            r_pin_error   <= 1'b0;
            r_pin_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_digits      <= w_digits_nxt;
            r_len         <= w_len_nxt;
            r_pin_valid   <= w_pin_valid_nxt;
            r_pin_error   <= w_pin_error_nxt;
            r_pin_timeout <= w_pin_timeout_nxt;
        end
    end

`ifdef PIN_MASK_EN
    localparam int RW = $clog2(REVEAL_CYCLES + 1);

    logic          w_reveal_load;
    logic [RW-1:0] w_reveal_val;
    logic          w_reveal_expired;
    logic          w_digit_shift;
    logic          w_hide;

    // A newly shifted-in digit opens the reveal window; any edit, submit or
    // timeout closes it so nothing older is ever shown raw.
    always_comb begin
        w_digit_shift = 1'b0;
        w_hide        = 1'b0;
        if (w_take && is_digit(io_pin.key_code)) begin
            w_digit_shift = (r_state == ST_IDLE) ||
                            ((r_state == ST_ENTRY) && (int'(r_len) < PIN_MAX_LEN));
        end
        if (r_state == ST_ENTRY) begin
            if (w_take) begin
                w_hide = (io_pin.key_code == KEY_BKSP)  ||
                         (io_pin.key_code == KEY_CLEAR) ||
                         (io_pin.key_code == KEY_SUBMIT);
            end else begin
                w_hide = w_tmr_expired;
            end
        end
        w_reveal_load = w_digit_shift || w_hide;
        w_reveal_val  = w_digit_shift ? RW'(REVEAL_CYCLES) : '0;
    end

    down_timer #(.WIDTH(RW)) u_reveal_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_reveal_load),
        .i_load_val (w_reveal_val),
        .o_expired  (w_reveal_expired)
    );
`endif

    // Display map: empty slots blank; held slots raw or masked.
    always_comb begin
        io_pin.bcd_packet = '0;
        for (int i = 0; i < PIN_MAX_LEN; i++) begin
            if (3'(i) >= r_len) begin
                io_pin.bcd_packet[i] = BCD_BLANK;
            end else begin
`ifdef PIN_MASK_EN
                io_pin.bcd_packet[i] = (i == 0 && !w_reveal_expired) ? r_digits[i] : BCD_DASH;
`else
                io_pin.bcd_packet[i] = r_digits[i];
`endif
            end
        end
    end

    assign io_pin.enable_o    = (r_state != ST_IDLE);
    assign io_pin.pin_valid   = r_pin_valid;
    assign io_pin.pin_error   = r_pin_error;
    assign io_pin.pin_timeout = r_pin_timeout;
    assign io_pin.pin_digits  = r_digits;
    assign io_pin.pin_len     = r_len;

endmodule

// File: tb/tb_pin_entry_buffer.sv
// -----------------------------------------------------------------------------
// tb_pin_entry_buffer
// Directed bench for pin_entry_buffer with shortened timer parameters.
// Table rows are applied one clock each; timer and reset corners are
// hand-written sequences. Build with PIN_MASK_EN defined to check masking.
// -----------------------------------------------------------------------------
module tb_pin_entry_buffer;
    import lock_pkg::*;

    localparam int MIN_LEN = 4;
    localparam int T_TO    = 20;
    localparam int T_HOLD  = 10;
    localparam int T_REV   = 5;

    logic clk;
    logic rst;

    pin_entry_buffer_if bus ();

    pin_entry_buffer #(
        .MIN_LEN        (MIN_LEN),
        .TIMEOUT_CYCLES (T_TO),
        .HOLD_CYCLES    (T_HOLD),
        .REVEAL_CYCLES  (T_REV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_pin (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        valid;
        logic [3:0]  code;
        logic [23:0] pkt;
        logic [2:0]  len;
        logic [23:0] dig;
        logic        en;
        logic        rdy;
        logic        pv;
        logic        pe;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [3:0] c, input logic [23:0] pkt,
                       input logic [2:0] len, input logic [23:0] dig, input logic en,
                       input logic rdy, input logic pv, input logic pe);
        vec_t r;
        r.valid = v; r.code = c; r.pkt = pkt; r.len = len; r.dig = dig;
        r.en = en; r.rdy = rdy; r.pv = pv; r.pe = pe;
        vecs.push_back(r);
    endtask

    // Called at posedge+1; leaves the bench at posedge+1 of the next edge.
    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.key_valid = vecs[i].valid;
            bus.key_code  = vecs[i].code;
            @(posedge clk); #1;
            bus.key_valid = 1'b0;
`ifndef PIN_MASK_EN
            check($sformatf("v%0d packet", i), 32'(bus.bcd_packet), 32'(vecs[i].pkt));
`endif
            check($sformatf("v%0d len", i),    32'(bus.pin_len),    32'(vecs[i].len));
            check($sformatf("v%0d digits", i), 32'(bus.pin_digits), 32'(vecs[i].dig));
            check($sformatf("v%0d enable", i), 32'(bus.enable_o),   32'(vecs[i].en));
            check($sformatf("v%0d ready", i),  32'(bus.key_ready),  32'(vecs[i].rdy));
            check($sformatf("v%0d valid", i),  32'(bus.pin_valid),  32'(vecs[i].pv));
            check($sformatf("v%0d error", i),  32'(bus.pin_error),  32'(vecs[i].pe));
            check($sformatf("v%0d tmo", i),    32'(bus.pin_timeout), 32'h0);
        end
    endtask

    task automatic send_key(input logic [3:0] c);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;

        // Table A: IDLE ignores edits, then 1,2,3,4,SUBMIT.
        add(1, KEY_SUBMIT, 24'hBBBBBB, 0, 24'h000000, 0, 1, 0, 0);
        add(1, KEY_BKSP,   24'hBBBBBB, 0, 24'h000000, 0, 1, 0, 0);
        add(1, 4'hF,       24'hBBBBBB, 0, 24'h000000, 0, 1, 0, 0);
        add(1, 4'h1,       24'hBBBBB1, 1, 24'h000001, 1, 1, 0, 0);
        add(1, 4'h2,       24'hBBBB12, 2, 24'h000012, 1, 1, 0, 0);
        add(1, 4'h3,       24'hBBB123, 3, 24'h000123, 1, 1, 0, 0);
        add(1, 4'h4,       24'hBB1234, 4, 24'h001234, 1, 1, 0, 0);
        add(0, 4'h9,       24'hBB1234, 4, 24'h001234, 1, 1, 0, 0);
        add(1, KEY_SUBMIT, 24'hBB1234, 4, 24'h001234, 1, 0, 1, 0);   // idx 8
        // Table B: overflow, backspace, clear, short submit, backspace to empty.
        add(1, 4'h1,       24'hBBBBB1, 1, 24'h000001, 1, 1, 0, 0);   // idx 9
        add(1, 4'h2,       24'hBBBB12, 2, 24'h000012, 1, 1, 0, 0);
        add(1, 4'h3,       24'hBBB123, 3, 24'h000123, 1, 1, 0, 0);
        add(1, 4'h4,       24'hBB1234, 4, 24'h001234, 1, 1, 0, 0);
        add(1, 4'h5,       24'hB12345, 5, 24'h012345, 1, 1, 0, 0);
        add(1, 4'h6,       24'h123456, 6, 24'h123456, 1, 1, 0, 0);
        add(1, 4'h7,       24'h123456, 6, 24'h123456, 1, 1, 0, 0);
        add(1, KEY_BKSP,   24'hB12345, 5, 24'h012345, 1, 1, 0, 0);
        add(1, 4'hF,       24'hB12345, 5, 24'h012345, 1, 1, 0, 0);
        add(1, KEY_CLEAR,  24'hBBBBBB, 0, 24'h000000, 0, 1, 0, 0);
        add(1, 4'h9,       24'hBBBBB9, 1, 24'h000009, 1, 1, 0, 0);
        add(1, 4'h8,       24'hBBBB98, 2, 24'h000098, 1, 1, 0, 0);
        add(1, KEY_SUBMIT, 24'hBBBBBB, 0, 24'h000000, 0, 1, 0, 1);
        add(0, 4'h0,       24'hBBBBBB, 0, 24'h000000, 0, 1, 0, 0);
        add(1, 4'h3,       24'hBBBBB3, 1, 24'h000003, 1, 1, 0, 0);
        add(1, 4'hB,       24'hBBBBB3, 1, 24'h000003, 1, 1, 0, 0);
        add(1, KEY_BKSP,   24'hBBBBBB, 0, 24'h000000, 0, 1, 0, 0);   // idx 25

        // Reset values.
        #2;
        check("rst packet",  32'(bus.bcd_packet), 32'hBBBBBB);
        check("rst digits",  32'(bus.pin_digits), 32'h0);
        check("rst len",     32'(bus.pin_len),    32'h0);
        check("rst ready",   32'(bus.key_ready),  32'h1);
        check("rst enable",  32'(bus.enable_o),   32'h0);
        check("rst pulses",  32'({bus.pin_valid, bus.pin_error, bus.pin_timeout}), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Submit then HOLD: key ignored, packet frozen, exit after T_HOLD.
        run_vectors(0, 8);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h7;
        @(posedge clk); #1;
        check("hold pv drop", 32'(bus.pin_valid), 32'h0);
        check("hold ready",   32'(bus.key_ready), 32'h0);
        repeat (T_HOLD - 2) @(posedge clk);
        #1;
        check("hold last en",  32'(bus.enable_o), 32'h1);
        check("hold last len", 32'(bus.pin_len),  32'h4);
`ifdef PIN_MASK_EN
        check("hold frozen pkt", 32'(bus.bcd_packet), 32'hBBAAAA);
`else
        check("hold frozen pkt", 32'(bus.bcd_packet), 32'hBB1234);
`endif
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        check("hold exit en",     32'(bus.enable_o),   32'h0);
        check("hold exit pkt",    32'(bus.bcd_packet), 32'hBBBBBB);
        check("hold exit ready",  32'(bus.key_ready),  32'h1);
        check("hold exit digits", 32'(bus.pin_digits), 32'h001234);
        check("hold exit len",    32'(bus.pin_len),    32'h0);

        run_vectors(9, 25);

        // Inactivity: key on the expiry cycle wins, then a real timeout.
        send_key(4'h5);
        repeat (T_TO - 1) @(posedge clk);
        #1;
        check("pre-expiry tmo", 32'(bus.pin_timeout), 32'h0);
        check("pre-expiry en",  32'(bus.enable_o),    32'h1);
        send_key(4'h6);
        check("expiry key tmo", 32'(bus.pin_timeout), 32'h0);
        check("expiry key len", 32'(bus.pin_len),     32'h2);
`ifndef PIN_MASK_EN
        check("expiry key pkt", 32'(bus.bcd_packet),  32'hBBBB56);
`endif
        repeat (T_TO - 1) @(posedge clk);
        #1;
        check("tmo not yet", 32'(bus.pin_timeout), 32'h0);
        @(posedge clk); #1;
        check("tmo pulse",  32'(bus.pin_timeout), 32'h1);
        check("tmo en",     32'(bus.enable_o),    32'h0);
        check("tmo len",    32'(bus.pin_len),     32'h0);
        check("tmo pkt",    32'(bus.bcd_packet),  32'hBBBBBB);
        check("tmo digits", 32'(bus.pin_digits),  32'h0);
        @(posedge clk); #1;
        check("tmo pulse drop", 32'(bus.pin_timeout), 32'h0);

        // Asynchronous reset mid-ENTRY.
        send_key(4'h1);
        send_key(4'h2);
        send_key(4'h3);
        check("pre-rst len", 32'(bus.pin_len), 32'h3);
        #3;
        rst = 1'b1;
        #1;
        check("async rst len",    32'(bus.pin_len),    32'h0);
        check("async rst pkt",    32'(bus.bcd_packet), 32'hBBBBBB);
        check("async rst digits", 32'(bus.pin_digits), 32'h0);
        check("async rst en",     32'(bus.enable_o),   32'h0);
        check("async rst ready",  32'(bus.key_ready),  32'h1);
        @(posedge clk); #1;
        check("async rst pulses", 32'({bus.pin_valid, bus.pin_error, bus.pin_timeout}), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post rst pulses", 32'({bus.pin_valid, bus.pin_error, bus.pin_timeout}), 32'h0);

        // Newest-digit reveal window (raw display without masking).
        do_reset();
        send_key(4'h1);
        send_key(4'h2);
        check("reveal digits", 32'(bus.pin_digits), 32'h000012);
`ifdef PIN_MASK_EN
        check("reveal start pkt", 32'(bus.bcd_packet), 32'hBBBBA2);
`else
        check("reveal start pkt", 32'(bus.bcd_packet), 32'hBBBB12);
`endif
        repeat (T_REV - 1) @(posedge clk);
        #1;
`ifdef PIN_MASK_EN
        check("reveal end pkt", 32'(bus.bcd_packet), 32'hBBBBA2);
`else
        check("reveal end pkt", 32'(bus.bcd_packet), 32'hBBBB12);
`endif
        @(posedge clk); #1;
`ifdef PIN_MASK_EN
        check("reveal over pkt", 32'(bus.bcd_packet), 32'hBBBBAA);
`else
        check("reveal over pkt", 32'(bus.bcd_packet), 32'hBBBB12);
`endif
        check("reveal raw digits", 32'(bus.pin_digits), 32'h000012);
        send_key(KEY_BKSP);
`ifdef PIN_MASK_EN
        check("bksp no reveal pkt", 32'(bus.bcd_packet), 32'hBBBBBA);
`else
        check("bksp pkt", 32'(bus.bcd_packet), 32'hBBBBB1);
`endif
        check("bksp len", 32'(bus.pin_len), 32'h1);
        send_key(KEY_CLEAR);
        check("final idle en", 32'(bus.enable_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
